serial_pe_accumulator: RTL and testbench

Signed multiply-accumulate processing element that sits directly downstream of the serial data loader. It consumes the loader's registered weight/feature byte pair and accumulate-enable strobe, and sums NUM_TERMS products per output pixel (9 for a 3x3 kernel). It then registers the finished sum into a result holding register with a valid/ready handshake toward the output writer. The loader's PE-clear pulse restarts accumulation between windows.

---
 rtl/serial_pe_accumulator.sv | 116 +++++++++++
 tb/tb_serial_pe_accumulator.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_pe_accumulator.sv
// Signed multiply-accumulate PE: sums NUM_TERMS weight*feature products per window
// and hands the sum to a valid/ready result register. Optional ReLU: define PE_RELU_EN.
module serial_pe_accumulator #(
   parameter int DATA_W    = 8,
   parameter int ACC_W     = 20,
   parameter int NUM_TERMS = 9
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     acc_en,
   input  logic signed [DATA_W-1:0] w_in,
   input  logic signed [DATA_W-1:0] f_in,
   output logic signed [ACC_W-1:0]  result,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [3:0]               term_cnt,
   output logic                     busy,
   output logic                     drop_err
);

   typedef enum logic {
      IDLE = 1'b0,
      ACC  = 1'b1
   } state_t;

   localparam logic [3:0] LAST_CNT = 4'(NUM_TERMS - 1);

   state_t                    state_reg, state_next;
   logic signed [ACC_W-1:0]   acc_reg, acc_next;
   logic [3:0]                cnt_reg, cnt_next;
   logic signed [ACC_W-1:0]   result_reg, result_next;
   logic                      valid_reg, valid_next;
   logic                      drop_reg, drop_next;
   logic                      complete;

   logic signed [2*DATA_W-1:0] product;
   logic signed [ACC_W-1:0]    product_ext;
   logic signed [ACC_W-1:0]    sum;
   logic signed [ACC_W-1:0]    load_val;

   // Full-precision signed product; the accumulator width leaves room for growth.
   assign product     = (2*DATA_W)'(w_in) * (2*DATA_W)'(f_in);
   assign product_ext = ACC_W'(product);
   assign sum         = acc_reg + product_ext;

`ifdef PE_RELU_EN
   assign load_val = sum[ACC_W-1] ? '0 : sum;
`else
   assign load_val = sum;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= IDLE;
         acc_reg    <= '0;
         cnt_reg    <= '0;
         result_reg <= '0;
         valid_reg  <= 1'b0;
         drop_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         acc_reg    <= acc_next;
         cnt_reg    <= cnt_next;
         result_reg <= result_next;
         valid_reg  <= valid_next;
         drop_reg   <= drop_next;
      end
   end

   // Window sequencing: clear beats a simultaneous term, the last term closes the window.
   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      cnt_next   = cnt_reg;
      complete   = 1'b0;
      if (clr) begin
         state_next = IDLE;
         acc_next   = '0;
         cnt_next   = '0;
      end else if (acc_en) begin
         if (cnt_reg == LAST_CNT) begin
            complete   = 1'b1;
            state_next = IDLE;
            acc_next   = '0;
            cnt_next   = '0;
         end else begin
            state_next = ACC;
            acc_next   = sum;
            cnt_next   = cnt_reg + 4'd1;
         end
      end
   end

   // Result holding register; a completion during an accepted handshake is not a drop.
   always_comb begin
      result_next = result_reg;
      valid_next  = valid_reg;
      drop_next   = drop_reg;
      if (valid_reg && res_ready)
         valid_next = 1'b0;
      if (complete) begin
         result_next = load_val;
         valid_next  = 1'b1;
         if (valid_reg && !res_ready)
            drop_next = 1'b1;
      end
   end

   assign result    = result_reg;
   assign res_valid = valid_reg;
   assign term_cnt  = cnt_reg;
   assign busy      = (state_reg == ACC);
   assign drop_err  = drop_reg;

endmodule

// File: tb/tb_serial_pe_accumulator.sv
// Scoreboard bench for serial_pe_accumulator: stimulus pushes expected results,
// a negedge monitor pops and compares on every accepted handshake.
module tb_serial_pe_accumulator;

   logic               clk = 1'b0;
   logic               rst;
   logic               clr;
   logic               acc_en;
   logic signed [7:0]  w_in;
   logic signed [7:0]  f_in;
   logic signed [19:0] result;
   logic               res_valid;
   logic               res_ready;
   logic [3:0]         term_cnt;
   logic               busy;
   logic               drop_err;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_q[$];

   serial_pe_accumulator #(.DATA_W(8), .ACC_W(20), .NUM_TERMS(9)) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .acc_en    (acc_en),
      .w_in      (w_in),
      .f_in      (f_in),
      .result    (result),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .term_cnt  (term_cnt),
      .busy      (busy),
      .drop_err  (drop_err)
   );

   always #5 clk = ~clk;

   function automatic int relu(input int v);
`ifdef PE_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Monitor: every accepted handshake must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_result: got %0d expected none", result);
         end else begin
            int e;
            e = exp_q.pop_front();
            $display("result delivered: %0d (expected %0d)", result, e);
            chk("result", int'(result), e);
         end
      end
   end

   task automatic send(input int w, input int f);
      acc_en = 1'b1;
      w_in   = 8'(w);
      f_in   = 8'(f);
      @(posedge clk);
      #1;
      acc_en = 1'b0;
   endtask

   task automatic window(input int w, input int f, input int n);
      for (int i = 0; i < n; i++) send(w, f);
   endtask

   task automatic wait_drain();
      int cyc;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 50) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("drain_pending", exp_q.size(), 0);
   endtask

   initial begin
      rst = 1'b0; clr = 1'b0; acc_en = 1'b0; w_in = '0; f_in = '0; res_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_result", int'(result), 0);
      chk("rst_valid", int'(res_valid), 0);
      chk("rst_cnt", int'(term_cnt), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_drop", int'(drop_err), 0);
      rst = 1'b1;

      // Basic window 3*2 x9
      res_ready = 1'b1;
      window(3, 2, 4);
      chk("mid_cnt", int'(term_cnt), 4);
      chk("mid_busy", int'(busy), 1);
      window(3, 2, 5);
      exp_q.push_back(54);
      chk("done_valid", int'(res_valid), 1);
      chk("done_cnt", int'(term_cnt), 0);
      chk("done_busy", int'(busy), 0);

      // Extreme operands, back-to-back windows
      window(-128, -128, 9);
      exp_q.push_back(147456);
      window(-128, 127, 9);
      exp_q.push_back(relu(-146304));
      wait_drain();

      // Two windows with no consumer: overwrite flagged
      res_ready = 1'b0;
      send(5, 1);
      window(0, 0, 8);
      chk("hold_result", int'(result), 5);
      chk("hold_valid", int'(res_valid), 1);
      chk("hold_drop", int'(drop_err), 0);
      send(7, 1);
      window(0, 0, 8);
      chk("ovw_result", int'(result), 7);
      chk("ovw_drop", int'(drop_err), 1);
      rst = 1'b0;
      #1;
      chk("rst2_result", int'(result), 0);
      chk("rst2_valid", int'(res_valid), 0);
      chk("rst2_drop", int'(drop_err), 0);
      chk("rst2_cnt", int'(term_cnt), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // clr with simultaneous acc_en, held result survives
      window(2, 1, 9);
      exp_q.push_back(18);
      window(10, 10, 4);
      chk("preclr_cnt", int'(term_cnt), 4);
      clr = 1'b1;
      send(10, 10);
      clr = 1'b0;
      chk("clr_cnt", int'(term_cnt), 0);
      chk("clr_busy", int'(busy), 0);
      chk("clr_result", int'(result), 18);
      chk("clr_valid", int'(res_valid), 1);
      res_ready = 1'b1;
      window(1, 1, 9);
      exp_q.push_back(9);
      wait_drain();

      // Completion coincides with acceptance of the previous result
      res_ready = 1'b0;
      window(1, 4, 9);
      exp_q.push_back(36);
      window(1, 2, 8);
      res_ready = 1'b1;
      send(1, 2);
      exp_q.push_back(18);
      chk("same_valid", int'(res_valid), 1);
      chk("same_result", int'(result), 18);
      chk("same_drop", int'(drop_err), 0);
      wait_drain();

      // Asynchronous reset mid-window
      window(2, 3, 5);
      chk("pre_rst_cnt", int'(term_cnt), 5);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_cnt", int'(term_cnt), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_result", int'(result), 0);
      chk("arst_valid", int'(res_valid), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      window(4, -3, 9);
      exp_q.push_back(relu(-108));
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
